// File: rtl/spi_i2s_pkg.sv
// Shared definitions for the SPI/I2S transmit controller: FSM encoding,
// word-size codes and small helpers used when a word is captured.
package spi_i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int SIZE_W   = 2;
    localparam int BITCNT_W = 6;

    localparam logic [SIZE_W-1:0] SIZE_8  = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_16 = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_24 = 2'b10;
    localparam logic [SIZE_W-1:0] SIZE_32 = 2'b11;

    // Bit counter load value: word length minus one.
    function automatic logic [BITCNT_W-1:0] bit_cnt_load(input logic [SIZE_W-1:0] size);
        logic [BITCNT_W-1:0] load;
        case (size)
            SIZE_8:  load = 6'd7;
            SIZE_16: load = 6'd15;
            SIZE_24: load = 6'd23;
            SIZE_32: load = 6'd31;
            default: load = 6'd7;
        endcase
        return load;
    endfunction

    // Left-align the active bits so the MSB of the word sits at bit 31;
    // bits above the word length are shifted out and never reach mosi.
    function automatic logic [31:0] align_word(input logic [31:0] data,
                                               input logic [SIZE_W-1:0] size);
        logic [31:0] aligned;
        case (size)
            SIZE_8:  aligned = {data[7:0],  24'd0};
            SIZE_16: aligned = {data[15:0], 16'd0};
            SIZE_24: aligned = {data[23:0], 8'd0};
            SIZE_32: aligned = data;
            default: aligned = {data[7:0],  24'd0};
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/spi_i2s_sck_tick.sv
// Half-period timer: emits a one-cycle tick every (div+1) cycles while
// enabled. The divider is latched at each reload so a new clk_div value
// only applies from the next half-period.
module spi_i2s_sck_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             reload_s;

    // Tick on terminal count; reload on start, on tick, or while disabled.
    always_comb begin
        tick_o   = en_i & (cnt_q == div_q);
        reload_s = start_i | ~en_i | tick_o;
        if (reload_s) begin
            cnt_d = {DIV_W{1'b0}};
            div_d = div_i;
        end else begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            div_d = div_q;
        end
    end

    // Counter and latched divider registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {DIV_W{1'b0}};
            div_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/spi_i2s_tx_ctrl.sv
// SPI/I2S transmit controller: pops words from a show-ahead TX FIFO and
// serialises them MSB first with programmable length, clock polarity and
// half-period. Consecutive words stream back-to-back under one chip select.
module spi_i2s_tx_ctrl
    import spi_i2s_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cpol,
    input  logic [1:0]       size_select,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [3:0]       fifo_fill,
    input  logic [31:0]      fifo_data,
    output logic             fifo_read,
    output logic             spi_sck,
    output logic             spi_cs_n,
    output logic             spi_mosi,
    output logic             busy,
    output logic             done
);

    state_e              state_q;
    state_e              state_d;
    logic [31:0]         shift_q;
    logic [31:0]         shift_d;
    logic [BITCNT_W-1:0] bit_cnt_q;
    logic [BITCNT_W-1:0] bit_cnt_d;
    logic                phase_q;
    logic                phase_d;
    logic                cpol_q;
    logic                cpol_d;
    logic                sck_q;
    logic                sck_d;
    logic                cs_n_q;
    logic                cs_n_d;
    logic                mosi_q;
    logic                mosi_d;
    logic                done_q;
    logic                done_d;
    logic                busy_q;

    logic                pop_ok_s;
    logic                rd_s;
    logic                tick_s;
    logic                tick_en_s;
    logic                last_edge_s;
    logic [31:0]         aligned_s;

    assign pop_ok_s    = enable & (fifo_fill != 4'd0);
    assign tick_en_s   = (state_q != ST_IDLE);
    assign aligned_s   = align_word(fifo_data, size_select);
    assign last_edge_s = tick_s & phase_q & (bit_cnt_q == 6'd0);

    // The pop strobe is suppressed while reset is asserted so a reset
    // cycle can never drain the FIFO.
    assign fifo_read = rd_s & rst_n;
    assign spi_sck   = sck_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;
    assign busy      = busy_q;
    assign done      = done_q;

    spi_i2s_sck_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (tick_en_s),
        .start_i (rd_s),
        .div_i   (clk_div),
        .tick_o  (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_ok_s) state_d = ST_SETUP;
                else          state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (tick_s) state_d = ST_SHIFT;
                else        state_d = ST_SETUP;
            end
            ST_SHIFT: begin
                if (last_edge_s && !pop_ok_s) state_d = ST_HOLD;
                else                          state_d = ST_SHIFT;
            end
            ST_HOLD: begin
                if (tick_s) state_d = ST_IDLE;
                else        state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output and datapath next-state logic.
    always_comb begin
        rd_s      = 1'b0;
        done_d    = 1'b0;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        cpol_d    = cpol_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = 1'b0;
                sck_d   = cpol;
                if (pop_ok_s) begin
                    rd_s      = 1'b1;
                    shift_d   = aligned_s;
                    bit_cnt_d = bit_cnt_load(size_select);
                    cpol_d    = cpol;
                    cs_n_d    = 1'b0;
                    mosi_d    = aligned_s[31];
                end else begin
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tick_s) phase_d = 1'b0;
                else        phase_d = phase_q;
            end
            ST_SHIFT: begin
                if (tick_s && !phase_q) begin
                    // Leading edge: sample point for the receiver.
                    sck_d   = ~cpol_q;
                    phase_d = 1'b1;
                end else if (tick_s) begin
                    // Trailing edge: the only place mosi is allowed to move.
                    sck_d   = cpol_q;
                    phase_d = 1'b0;
                    if (bit_cnt_q != 6'd0) begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        shift_d   = shift_q << 1;
                        mosi_d    = shift_q[30];
                    end else begin
                        done_d = 1'b1;
                        if (pop_ok_s) begin
                            rd_s      = 1'b1;
                            shift_d   = aligned_s;
                            bit_cnt_d = bit_cnt_load(size_select);
                            cpol_d    = cpol;
                            sck_d     = cpol;
                            mosi_d    = aligned_s[31];
                        end else begin
                            mosi_d = mosi_q;
                        end
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            ST_HOLD: begin
                if (tick_s) cs_n_d = 1'b1;
                else        cs_n_d = 1'b0;
            end
            default: begin
                cs_n_d = 1'b1;
                sck_d  = cpol;
                mosi_d = 1'b0;
            end
        endcase
    end

    // Datapath and serial output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q   <= 32'd0;
            bit_cnt_q <= 6'd0;
            phase_q   <= 1'b0;
            cpol_q    <= 1'b0;
            sck_q     <= cpol;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            cpol_q    <= cpol_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_i2s_tx_ctrl.sv
// Scoreboard bench for spi_i2s_tx_ctrl: stimulus pushes expected words,
// a negedge monitor reassembles bits sampled on leading sck edges and
// compares them whenever done pulses.
module tb_spi_i2s_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cpol;
    logic [1:0]  size_select;
    logic [7:0]  clk_div;
    logic [3:0]  fifo_fill;
    logic [31:0] fifo_data;
    logic        fifo_read;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] word;
        logic [31:0] nbits;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        tb_cpol = 1'b0;
    logic        rd_pulse_q = 1'b0;
    logic        rd_empty_q = 1'b0;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int done_count = 0;
    int lead_count = 0;
    int cs_fall_count = 0;
    int low_cnt = 0;
    int last_low = 0;
    logic [31:0] rx_word = 32'd0;
    int          rx_cnt = 0;
    logic prev_sck = 1'b0;
    logic prev_cs_n = 1'b1;
    logic prev_mosi = 1'b0;

    assign fifo_fill = 4'(wr_ptr - rd_ptr);
    assign fifo_data = mem[rd_ptr[3:0]];

    spi_i2s_tx_ctrl #(.DIV_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cpol        (cpol),
        .size_select (size_select),
        .clk_div     (clk_div),
        .fifo_fill   (fifo_fill),
        .fifo_data   (fifo_data),
        .fifo_read   (fifo_read),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] exp_w,
                             input logic [31:0] nbits, input bit expect_it);
        exp_t e;
        mem[wr_ptr[3:0]] = w;
        wr_ptr++;
        if (expect_it) begin
            e.word  = exp_w;
            e.nbits = nbits;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || spi_cs_n !== 1'b1) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_timeout"}, 32'(n < max), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_leads(input string nm, input int target, input int max);
        int n;
        n = 0;
        while (lead_count < target && n < max) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_timeout"}, 32'(n < max), 32'd1);
    endtask

    // FIFO model: pops on the same edge the DUT captures the head word.
    always @(posedge clk) begin
        rd_pulse_q <= fifo_read;
        rd_empty_q <= fifo_read && (fifo_fill == 4'd0);
        if (fifo_read && fifo_fill != 4'd0) rd_ptr <= rd_ptr + 1;
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n == 1'b0) begin
            rx_word = 32'd0;
            rx_cnt  = 0;
        end else begin
            if (rd_pulse_q) begin
                rd_count++;
                check("fifo_read_nonempty", {31'd0, rd_empty_q}, 32'd0);
            end
            if (done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", rx_word, e.word);
                    check("word_bits", 32'(rx_cnt), e.nbits);
                end
                rx_word = 32'd0;
                rx_cnt  = 0;
            end
            if (!spi_cs_n && spi_sck != prev_sck && spi_sck == ~tb_cpol) begin
                lead_count++;
                rx_word = {rx_word[30:0], spi_mosi};
                rx_cnt++;
            end
            if (!spi_cs_n && !prev_cs_n && spi_mosi !== prev_mosi) begin
                check("mosi_on_trailing", {31'd0, (spi_sck == tb_cpol && prev_sck != tb_cpol)}, 32'd1);
            end
            if (!spi_cs_n && prev_cs_n) cs_fall_count++;
        end
        if (!spi_cs_n) begin
            low_cnt++;
        end else if (low_cnt != 0) begin
            last_low = low_cnt;
            low_cnt  = 0;
        end
        prev_sck  = spi_sck;
        prev_cs_n = spi_cs_n;
        prev_mosi = spi_mosi;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, d0, l0, c0;
        logic [3:0] fill0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rst_n = 1'b0; enable = 1'b0; cpol = 1'b0; size_select = 2'b00; clk_div = 8'd1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 8-bit word, H=2: 2 + 32 + 2 = 36 cycles of chip select.
        rd0 = rd_count; d0 = done_count; l0 = lead_count;
        enable = 1'b1;
        push_word(32'h0000_00A5, 32'h0000_00A5, 32'd8, 1'b1);
        wait_idle("t1", 200);
        check("t1_cs_low", 32'(last_low), 32'd36);
        check("t1_reads", 32'(rd_count - rd0), 32'd1);
        check("t1_dones", 32'(done_count - d0), 32'd1);
        check("t1_leads", 32'(lead_count - l0), 32'd8);

        // Three 32-bit words back-to-back, H=1: 1 + 192 + 1 = 194 cycles.
        rd0 = rd_count; d0 = done_count; l0 = lead_count; c0 = cs_fall_count;
        size_select = 2'b11; clk_div = 8'd0;
        push_word(32'h1234_5678, 32'h1234_5678, 32'd32, 1'b1);
        push_word(32'h9ABC_DEF0, 32'h9ABC_DEF0, 32'd32, 1'b1);
        push_word(32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'd32, 1'b1);
        wait_idle("t2", 500);
        check("t2_leads", 32'(lead_count - l0), 32'd96);
        check("t2_dones", 32'(done_count - d0), 32'd3);
        check("t2_reads", 32'(rd_count - rd0), 32'd3);
        check("t2_cs_falls", 32'(cs_fall_count - c0), 32'd1);
        check("t2_cs_low", 32'(last_low), 32'd194);

        // cpol=1, 16-bit word, H=2: 2 + 64 + 2 = 68 cycles.
        enable = 1'b0; cpol = 1'b1; tb_cpol = 1'b1; size_select = 2'b01; clk_div = 8'd1;
        repeat (2) @(negedge clk);
        check("t3_sck_idle", {31'd0, spi_sck}, 32'd1);
        l0 = lead_count; d0 = done_count;
        push_word(32'h0000_8001, 32'h0000_8001, 32'd16, 1'b1);
        enable = 1'b1;
        wait_idle("t3", 300);
        check("t3_leads", 32'(lead_count - l0), 32'd16);
        check("t3_dones", 32'(done_count - d0), 32'd1);
        check("t3_cs_low", 32'(last_low), 32'd68);
        check("t3_sck_idle_after", {31'd0, spi_sck}, 32'd1);

        // Empty FIFO with enable held high: nothing may happen.
        cpol = 1'b0; tb_cpol = 1'b0; size_select = 2'b00;
        @(negedge clk);
        rd0 = rd_count; c0 = cs_fall_count;
        begin
            int activity;
            activity = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (busy || !spi_cs_n || fifo_read) activity++;
            end
            check("t4_activity", 32'(activity), 32'd0);
        end
        check("t4_reads", 32'(rd_count - rd0), 32'd0);
        check("t4_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);

        // Enable dropped mid-bit 3 with two words queued.
        rd0 = rd_count; d0 = done_count; l0 = lead_count;
        push_word(32'h0000_003C, 32'h0000_003C, 32'd8, 1'b1);
        push_word(32'h0000_00C3, 32'h0000_00C3, 32'd8, 1'b0);
        wait_leads("t5_lead", l0 + 5, 200);
        enable = 1'b0;
        wait_idle("t5", 200);
        check("t5_reads", 32'(rd_count - rd0), 32'd1);
        check("t5_dones", 32'(done_count - d0), 32'd1);
        check("t5_fill", {28'd0, fifo_fill}, 32'd1);
        check("t5_cs_low", 32'(last_low), 32'd36);
        wr_ptr = rd_ptr;
        @(negedge clk);

        // Reset for one cycle in the middle of a word.
        rd0 = rd_count; d0 = done_count; l0 = lead_count;
        enable = 1'b1;
        push_word(32'h0000_00F0, 32'h0000_00F0, 32'd8, 1'b0);
        push_word(32'h0000_000F, 32'h0000_000F, 32'd8, 1'b0);
        wait_leads("t6_lead", l0 + 3, 200);
        fill0 = fifo_fill;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("t6_sck", {31'd0, spi_sck}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_fill", {28'd0, fifo_fill}, {28'd0, fill0});
        enable = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_reads", 32'(rd_count - rd0), 32'd1);
        check("t6_dones", 32'(done_count - d0), 32'd0);
        check("t6_fill_after", {28'd0, fifo_fill}, 32'd1);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        wr_ptr = rd_ptr;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
